mat_mem_responder: RTL and testbench
====================================

MAT_MEM_RESPONDER -- requirements
Module: mat_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, word address width.
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 Parameter OP_ADDR, default 0, word address of the operation/metadata word.
REQ-004 clock  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 address  in  ADDR_WIDTH  engine-port word address.
REQ-007 data  in  DATA_WIDTH  engine-port write data.
REQ-008 read  in  1  engine-port read request.
REQ-009 write  in  1  engine-port write request.
REQ-010 rdata  out  DATA_WIDTH  engine-port read data.
REQ-011 op_code  out  4  metadata word bits [3:0].
REQ-012 dimA1, dimA2, dimB1, dimB2  out  6 each  metadata bits [9:4], [15:10], [21:16], [27:22].
REQ-013 host_addr  in  ADDR_WIDTH  host-port word address.
REQ-014 host_wdata  in  DATA_WIDTH  host-port write data.
REQ-015 host_read, host_write  in  1 each  host-port requests, held until host_ack.
REQ-016 host_ack  out  1  host request accepted this cycle.
REQ-017 host_rdata  out  DATA_WIDTH  host read data.
REQ-018 host_rvalid  out  1  host_rdata valid pulse.
REQ-019 busy  out  1  operation pending (op_code != 0).
REQ-020 done  out  1  one-cycle operation-complete pulse.
REQ-021 host_err  out  1  one-cycle pulse: host write to OP_ADDR dropped.

Function
REQ-022 Storage: 2^ADDR_WIDTH words of DATA_WIDTH; OP_ADDR held in a dedicated metadata register, not the array.
REQ-023 Engine port has fixed priority; at most one access (engine or host) is served per cycle.
REQ-024 Engine write: array[address] <= data at the edge; write at OP_ADDR loads the metadata register.
REQ-025 Engine read: rdata <= array[address] (or metadata register at OP_ADDR) at the edge; 1-cycle latency; rdata holds until next engine read.
REQ-026 Engine read and write asserted together: write performed, read ignored, rdata holds.
REQ-027 Host request served only when read=0 and write=0; host_ack asserted combinationally that cycle; otherwise host waits, no ack.
REQ-028 Host read: host_rdata registered at accept edge, host_rvalid pulses the following cycle; host_write takes priority over host_read.
REQ-029 Host write at OP_ADDR while busy=1: dropped, host_ack=1, host_err pulses next cycle; metadata unchanged.
REQ-030 Metadata outputs and busy are registered decodes of the metadata register; a write is visible the cycle after its edge.
REQ-031 done pulses the cycle after an engine write of 0 to OP_ADDR while busy=1; engine write of 0 while idle produces no done.
REQ-032 Read-after-write to the same address returns the new value on the next read (no stale data).
REQ-033 Metadata bits [31:28] are stored and read back unmodified.

Reset
REQ-034 Async reset clears metadata register (op_code=0, dims=0, busy=0), rdata=0, host_rdata=0, host_rvalid=0, done=0, host_err=0; array contents not reset.
REQ-035 host_ack is 0 during reset; reset mid-operation drops the operation without a done pulse.

Verification
REQ-036 Host writes 0xABCD at 100, then reads 100 -> host_ack on each accept, host_rvalid one cycle after the read accept, host_rdata=0xABCD.
REQ-037 Host writes {op=1, dimA1=16, dimA2=24} to OP_ADDR -> next cycle op_code=1, dimA1=16, dimA2=24, busy=1.
REQ-038 Host write to 101 held while engine reads 200 for 3 cycles -> host_ack only in the 4th cycle; engine rdata one cycle after each read.
REQ-039 Engine writes 0 to OP_ADDR while busy -> done high exactly 1 cycle, busy=0; repeat while idle -> no done.
REQ-040 Host writes OP_ADDR while busy -> host_err pulse, op_code unchanged.
REQ-041 Assert reset mid-operation with busy=1 -> all outputs at reset values immediately, no done; previously written array word 100 still reads 0xABCD.

Source files
------------

// File: rtl/mat_mem_responder.sv
// ---------------------------------------------------------------------------
// mat_mem_responder
//
// Word-addressed memory shared by a matrix engine and a host. The word at
// OP_ADDR is not stored in the array but in a dedicated metadata register
// whose fields (op code and four matrix dimensions) are decoded onto output
// ports. A non-zero op code means an operation is pending (busy); the engine
// clears it by writing 0 to OP_ADDR, which raises a one-cycle done pulse.
//
// The engine port has fixed priority. The host port is served only in a cycle
// with no engine request, and its requests are held until host_ack.
//
// Ports
//   clock, reset            single clock, asynchronous active-high reset
//   address/data/read/write engine request (read data on rdata, 1-cycle latency)
//   rdata                   engine read data, holds until the next engine read
//   op_code, dimA1..dimB2   decoded metadata fields
//   host_addr/host_wdata    host request address / write data
//   host_read/host_write    host requests (write wins when both are set)
//   host_ack                combinational: host request accepted this cycle
//   host_rdata/host_rvalid  host read data and its one-cycle valid pulse
//   busy                    operation pending (op_code != 0)
//   done                    one-cycle pulse: engine cleared a pending operation
//   host_err                one-cycle pulse: host write to OP_ADDR dropped
// ---------------------------------------------------------------------------
module mat_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_ADDR    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  // engine port
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] rdata,
  // metadata decode
  output logic [3:0]            op_code,
  output logic [5:0]            dimA1,
  output logic [5:0]            dimA2,
  output logic [5:0]            dimB1,
  output logic [5:0]            dimB2,
  // host port
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_read,
  input  logic                  host_write,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  // status
  output logic                  busy,
  output logic                  done,
  output logic                  host_err
);

  localparam int unsigned            DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  OP_WORD = ADDR_WIDTH'(OP_ADDR);

  // Storage. The array entry at OP_ADDR exists but is never written or read.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_meta;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_host_rdata;
  logic                  r_host_rvalid;
  logic                  r_done;
  logic                  r_host_err;

  // Request decode
  logic                  w_eng_wr;
  logic                  w_eng_rd;
  logic                  w_host_sel;
  logic                  w_host_wr;
  logic                  w_host_rd;
  logic                  w_busy;
  logic                  w_eng_op;
  logic                  w_host_op;
  logic                  w_host_drop;
  logic                  w_meta_eng_ld;
  logic                  w_meta_host_ld;
  // Shared array ports (only one access is served per cycle)
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Engine write wins over a simultaneous engine read; the read is ignored.
  assign w_eng_wr   = write;
  assign w_eng_rd   = read & ~write;

  // Host is served only in a cycle with no engine request; reset masks ack so
  // nothing is accepted while the block is held in reset.
  assign w_host_sel = ~reset & ~read & ~write & (host_read | host_write);
  assign w_host_wr  = w_host_sel & host_write;
  assign w_host_rd  = w_host_sel & host_read & ~host_write;

  assign w_busy     = (r_meta[3:0] != 4'd0);
  assign w_eng_op   = (address   == OP_WORD);
  assign w_host_op  = (host_addr == OP_WORD);

  // A host write to OP_ADDR during an operation is acknowledged but dropped,
  // so the host cannot overwrite metadata the engine is working from.
  assign w_host_drop    = w_host_wr & w_host_op & w_busy;
  assign w_meta_eng_ld  = w_eng_wr & w_eng_op;
  assign w_meta_host_ld = w_host_wr & w_host_op & ~w_busy;

  assign w_mem_we    = (w_eng_wr & ~w_eng_op) | (w_host_wr & ~w_host_op);
  assign w_mem_waddr = w_eng_wr ? address : host_addr;
  assign w_mem_wdata = w_eng_wr ? data    : host_wdata;

  // One read path serves whichever port is reading this cycle.
  assign w_rd_addr = read ? address : host_addr;
  assign w_rd_word = (w_rd_addr == OP_WORD) ? r_meta : r_mem[w_rd_addr];

  // NOTE: the array has no reset branch; clearing thousands of words in one
  // cycle is not implementable as RAM, and its contents must survive reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values and the order of statements does not matter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta        <= '0;
      r_rdata       <= '0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
      r_done        <= 1'b0;
      r_host_err    <= 1'b0;
    end else begin
      if (w_meta_eng_ld) begin
        r_meta <= data;
      end else if (w_meta_host_ld) begin
        r_meta <= host_wdata;
      end

      if (w_eng_rd) begin
        r_rdata <= w_rd_word;
      end

      if (w_host_rd) begin
        r_host_rdata <= w_rd_word;
      end

      r_host_rvalid <= w_host_rd;
      // Clearing an idle register is not a completion.
      r_done        <= w_meta_eng_ld & (data == '0) & w_busy;
      r_host_err    <= w_host_drop;
    end
  end

  assign rdata       = r_rdata;
  assign host_rdata  = r_host_rdata;
  assign host_rvalid = r_host_rvalid;
  assign host_ack    = w_host_sel;
  assign done        = r_done;
  assign host_err    = r_host_err;
  assign busy        = w_busy;

  assign op_code = r_meta[3:0];
  assign dimA1   = r_meta[9:4];
  assign dimA2   = r_meta[15:10];
  assign dimB1   = r_meta[21:16];
  assign dimB2   = r_meta[27:22];

endmodule

// File: tb/tb_mat_mem_responder.sv
module tb_mat_mem_responder;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam logic [AW-1:0] OPA = '0;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          read, write;
  logic [DW-1:0] rdata;
  logic [3:0]    op_code;
  logic [5:0]    dimA1, dimA2, dimB1, dimB2;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_read, host_write;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          busy, done, host_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mat_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OP_ADDR(0)) dut (
    .clock(clock), .reset(reset),
    .address(address), .data(data), .read(read), .write(write), .rdata(rdata),
    .op_code(op_code), .dimA1(dimA1), .dimA2(dimA2), .dimB1(dimB1), .dimB2(dimB2),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_read(host_read), .host_write(host_write), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .busy(busy), .done(done), .host_err(host_err)
  );

  typedef struct {
    logic          rd, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          hrd, hwr;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
    logic          e_ack;   // combinational, before the edge
    logic [DW-1:0] e_rdata; // everything below: after the edge
    logic [DW-1:0] e_hrdata;
    logic          e_rv, e_done, e_err;
    logic [DW-1:0] e_meta;  // expected metadata word (fields checked by slice)
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic rd, logic wr, logic [AW-1:0] addr, logic [DW-1:0] d,
    logic hrd, logic hwr, logic [AW-1:0] haddr, logic [DW-1:0] hwd,
    logic ack, logic [DW-1:0] rdat, logic [DW-1:0] hrdat,
    logic rv, logic dn, logic er, logic [DW-1:0] meta);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.data = d;
    v.hrd = hrd; v.hwr = hwr; v.haddr = haddr; v.hwdata = hwd;
    v.e_ack = ack; v.e_rdata = rdat; v.e_hrdata = hrdat;
    v.e_rv = rv; v.e_done = dn; v.e_err = er; v.e_meta = meta;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic hrd, input logic hwr, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    read = rd; write = wr; address = a; data = d;
    host_read = hrd; host_write = hwr; host_addr = ha; host_wdata = hd;
  endtask

  task automatic check_meta(input string tag, input logic [DW-1:0] m);
    check({tag, " op_code"}, DW'(op_code), DW'(m[3:0]));
    check({tag, " dimA1"},   DW'(dimA1),   DW'(m[9:4]));
    check({tag, " dimA2"},   DW'(dimA2),   DW'(m[15:10]));
    check({tag, " dimB1"},   DW'(dimB1),   DW'(m[21:16]));
    check({tag, " dimB2"},   DW'(dimB2),   DW'(m[27:22]));
    check({tag, " busy"},    DW'(busy),    DW'(m[3:0] != 4'd0));
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic apply(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    drive(v.rd, v.wr, v.addr, v.data, v.hrd, v.hwr, v.haddr, v.hwdata);
    #1;
    check({t, " host_ack"}, DW'(host_ack), DW'(v.e_ack));
    @(posedge clock); #1;
    check({t, " rdata"},       rdata,             v.e_rdata);
    check({t, " host_rdata"},  host_rdata,        v.e_hrdata);
    check({t, " host_rvalid"}, DW'(host_rvalid),  DW'(v.e_rv));
    check({t, " done"},        DW'(done),         DW'(v.e_done));
    check({t, " host_err"},    DW'(host_err),     DW'(v.e_err));
    check_meta(t, v.e_meta);
  endtask

  task automatic check_reset_state(input string t);
    check({t, " host_ack"},    DW'(host_ack),    '0);
    check({t, " rdata"},       rdata,            '0);
    check({t, " host_rdata"},  host_rdata,       '0);
    check({t, " host_rvalid"}, DW'(host_rvalid), '0);
    check({t, " done"},        DW'(done),        '0);
    check({t, " host_err"},    DW'(host_err),    '0);
    check_meta(t, '0);
  endtask

  initial begin
    // rd wr addr data | hrd hwr haddr hwdata | ack rdata hrdata rv done err meta
    vq.push_back(mk(0,1,12'd200,32'h1111_2222, 0,0,12'd0,32'h0,          0,32'h0,        32'h0,        0,0,0,32'h0));
    vq.push_back(mk(1,0,12'd200,32'h0,         0,0,12'd0,32'h0,          0,32'h1111_2222,32'h0,        0,0,0,32'h0));
    vq.push_back(mk(0,1,12'd200,32'h3333_3333, 0,0,12'd0,32'h0,          0,32'h1111_2222,32'h0,        0,0,0,32'h0));
    vq.push_back(mk(1,0,12'd200,32'h0,         0,0,12'd0,32'h0,          0,32'h3333_3333,32'h0,        0,0,0,32'h0));
    vq.push_back(mk(1,1,12'd300,32'h5555_5555, 0,0,12'd0,32'h0,          0,32'h3333_3333,32'h0,        0,0,0,32'h0));
    vq.push_back(mk(1,0,12'd300,32'h0,         0,0,12'd0,32'h0,          0,32'h5555_5555,32'h0,        0,0,0,32'h0));
    vq.push_back(mk(0,0,12'd0,  32'h0,         0,1,12'd100,32'h0000_ABCD,1,32'h5555_5555,32'h0,        0,0,0,32'h0));
    vq.push_back(mk(0,0,12'd0,  32'h0,         1,0,12'd100,32'h0,        1,32'h5555_5555,32'h0000_ABCD,1,0,0,32'h0));
    vq.push_back(mk(0,0,12'd0,  32'h0,         0,0,12'd0,32'h0,          0,32'h5555_5555,32'h0000_ABCD,0,0,0,32'h0));
    vq.push_back(mk(0,0,12'd0,  32'h0,         1,1,12'd102,32'h0000_0077,1,32'h5555_5555,32'h0000_ABCD,0,0,0,32'h0));
    vq.push_back(mk(0,0,12'd0,  32'h0,         1,0,12'd102,32'h0,        1,32'h5555_5555,32'h0000_0077,1,0,0,32'h0));
    vq.push_back(mk(0,1,12'd400,32'h0000_4444, 1,0,12'd100,32'h0,        0,32'h5555_5555,32'h0000_0077,0,0,0,32'h0));
    vq.push_back(mk(0,1,OPA,    32'h0,         0,0,12'd0,32'h0,          0,32'h5555_5555,32'h0000_0077,0,0,0,32'h0));
    vq.push_back(mk(0,0,12'd0,  32'h0,         0,1,OPA,32'hA000_6101,    1,32'h5555_5555,32'h0000_0077,0,0,0,32'hA000_6101));
    vq.push_back(mk(1,0,OPA,    32'h0,         0,0,12'd0,32'h0,          0,32'hA000_6101,32'h0000_0077,0,0,0,32'hA000_6101));
    vq.push_back(mk(0,0,12'd0,  32'h0,         0,1,OPA,32'h0000_0002,    1,32'hA000_6101,32'h0000_0077,0,0,1,32'hA000_6101));
    vq.push_back(mk(0,0,12'd0,  32'h0,         0,0,12'd0,32'h0,          0,32'hA000_6101,32'h0000_0077,0,0,0,32'hA000_6101));
    vq.push_back(mk(0,0,12'd0,  32'h0,         1,0,OPA,32'h0,            1,32'hA000_6101,32'hA000_6101,1,0,0,32'hA000_6101));
    vq.push_back(mk(0,1,OPA,    32'h0,         0,0,12'd0,32'h0,          0,32'hA000_6101,32'hA000_6101,0,1,0,32'h0));
    vq.push_back(mk(0,0,12'd0,  32'h0,         0,0,12'd0,32'h0,          0,32'hA000_6101,32'hA000_6101,0,0,0,32'h0));
    vq.push_back(mk(0,1,OPA,    32'h0,         0,0,12'd0,32'h0,          0,32'hA000_6101,32'hA000_6101,0,0,0,32'h0));
    vq.push_back(mk(0,1,OPA,    32'h0FC5_0003, 0,0,12'd0,32'h0,          0,32'hA000_6101,32'hA000_6101,0,0,0,32'h0FC5_0003));
    vq.push_back(mk(0,0,12'd0,  32'h0,         0,1,OPA,32'h0000_1234,    1,32'hA000_6101,32'hA000_6101,0,0,1,32'h0FC5_0003));
    vq.push_back(mk(0,1,OPA,    32'h0,         0,0,12'd0,32'h0,          0,32'hA000_6101,32'hA000_6101,0,1,0,32'h0));
    vq.push_back(mk(0,0,12'd0,  32'h0,         0,1,OPA,32'h0000_0005,    1,32'hA000_6101,32'hA000_6101,0,0,0,32'h0000_0005));
    vq.push_back(mk(1,0,12'd400,32'h0,         0,0,12'd0,32'h0,          0,32'h0000_4444,32'hA000_6101,0,0,0,32'h0000_0005));

    // Reset state
    reset = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    foreach (vq[i]) apply(vq[i], i);

    // Host write held off by three back-to-back engine reads.
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 12'd200, '0, 0, 1, 12'd101, 32'h0000_BEEF);
      #1;
      check($sformatf("hold%0d host_ack", c), DW'(host_ack), '0);
      @(posedge clock); #1;
      check($sformatf("hold%0d rdata", c), rdata, 32'h3333_3333);
      check($sformatf("hold%0d host_rvalid", c), DW'(host_rvalid), '0);
    end
    drive(0, 0, '0, '0, 0, 1, 12'd101, 32'h0000_BEEF);
    #1;
    check("hold3 host_ack", DW'(host_ack), 32'd1);
    @(posedge clock); #1;
    drive(0, 0, '0, '0, 1, 0, 12'd101, '0);
    @(posedge clock); #1;
    check("hold rd host_rdata", host_rdata, 32'h0000_BEEF);
    check("hold rd host_rvalid", DW'(host_rvalid), 32'd1);
    check("hold rd rdata kept", rdata, 32'h3333_3333);

    // Reset mid-operation (busy=1, op_code=5 from the table).
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(posedge clock); #1;
    check("pre-reset busy", DW'(busy), 32'd1);
    drive(0, 0, '0, '0, 1, 0, 12'd100, '0);
    #1;
    reset = 1'b1;
    #1;
    check_reset_state("midrst");
    drive(0, 1, OPA, '0, 0, 0, '0, '0);
    @(posedge clock); #1;
    check_reset_state("midrst edge");
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("postrst done", DW'(done), '0);
    check("postrst busy", DW'(busy), '0);
    drive(0, 0, '0, '0, 1, 0, 12'd100, '0);
    #1;
    check("postrst host_ack", DW'(host_ack), 32'd1);
    @(posedge clock); #1;
    check("postrst host_rdata", host_rdata, 32'h0000_ABCD);
    check("postrst host_rvalid", DW'(host_rvalid), 32'd1);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    @(posedge clock); #1;
    check("postrst rvalid drop", DW'(host_rvalid), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
